tone_bank: RTL and testbench

TONE_BANK -- requirements
Module: tone_bank

---
 rtl/tone_pkg.sv | 23 ++
 rtl/tone_channel.sv | 103 ++++++++++
 rtl/tone_bank.sv | 95 +++++++++
 tb/tb_tone_bank.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared defaults and the per-channel tone configuration record.
// Fields are held at TONE_MAX_PW bits; channels zero-extend narrower PW values.
package tone_pkg;

    localparam int unsigned TONE_CLK_F  = 32;
    localparam int unsigned TONE_CH     = 4;
    localparam int unsigned TONE_PW     = 20;
    localparam int unsigned TONE_MAX_PW = 32;

    typedef struct packed {
        logic [TONE_MAX_PW-1:0] period;
        logic [TONE_MAX_PW-1:0] high;
    } tone_cfg_t;

    function automatic tone_cfg_t tone_cfg(input logic [TONE_MAX_PW-1:0] period,
                                           input logic [TONE_MAX_PW-1:0] high);
        tone_cfg_t c;
        c.period = period;
        c.high   = high;
        return c;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: active/shadow configuration, microsecond counter and
// registered tone/wrap outputs. Shadow loads only at a period boundary or when silent.
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned PW = TONE_PW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_tick,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [PW-1:0] i_wr_period,
    input  logic [PW-1:0] i_wr_high,
    input  logic          i_en,
    output logic          o_tone,
    output logic          o_wrap,
    output logic          o_pending
);

    tone_cfg_t               r_act;
    tone_cfg_t               r_shd;
    logic                    r_pend;
    logic [PW-1:0]           r_cnt;
    logic                    r_tone;
    logic                    r_wrap;

    tone_cfg_t               w_act_d;
    tone_cfg_t               w_shd_d;
    tone_cfg_t               w_wr_cfg;
    logic                    w_pend_d;
    logic [PW-1:0]           w_cnt_d;
    logic                    w_tone_d;
    logic                    w_wrap_d;
    logic                    w_live;
    logic                    w_at_end;
    logic [TONE_MAX_PW-1:0]  w_cnt_ext;

    assign w_wr_cfg  = tone_cfg(TONE_MAX_PW'(i_wr_period), TONE_MAX_PW'(i_wr_high));
    assign w_cnt_ext = TONE_MAX_PW'(r_cnt);
    assign w_live    = (r_act.period != '0);
    assign w_at_end  = w_live && (w_cnt_ext == r_act.period - TONE_MAX_PW'(1));

    always_comb begin
        w_act_d  = r_act;
        w_shd_d  = r_shd;
        w_pend_d = r_pend;
        w_cnt_d  = r_cnt;
        w_wrap_d = 1'b0;
        if (i_sync) begin
            // Sync realigns phase; a same-cycle write bypasses the shadow stage.
            w_cnt_d  = '0;
            w_pend_d = 1'b0;
            if (i_wr) begin
                w_act_d = w_wr_cfg;
                w_shd_d = w_wr_cfg;
            end else if (r_pend) begin
                w_act_d = r_shd;
            end
        end else begin
            if (i_tick) begin
                if (!w_live || w_at_end) begin
                    w_cnt_d  = '0;
                    w_wrap_d = w_at_end && i_en;
                    if (r_pend) begin
                        w_act_d  = r_shd;
                        w_pend_d = 1'b0;
                    end
                end else begin
                    w_cnt_d = r_cnt + PW'(1);
                end
            end
            if (i_wr) begin
                w_shd_d  = w_wr_cfg;
                w_pend_d = 1'b1;
            end
        end
        w_tone_d = i_en && w_live && (w_cnt_ext < r_act.high);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act  <= '0;
            r_shd  <= '0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_tone <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_act  <= w_act_d;
            r_shd  <= w_shd_d;
            r_pend <= w_pend_d;
            r_cnt  <= w_cnt_d;
            r_tone <= w_tone_d;
            r_wrap <= w_wrap_d;
        end
    end

    assign o_tone    = r_tone;
    assign o_wrap    = r_wrap;
    assign o_pending = r_pend;

endmodule

// File: rtl/tone_bank.sv
// Bank of CH tone channels sharing a microsecond prescaler, a phase-sync
// strobe and a registered count of active tone outputs.
module tone_bank
    import tone_pkg::*;
#(
    parameter int unsigned CLK_F = TONE_CLK_F,
    parameter int unsigned CH    = TONE_CH,
    parameter int unsigned PW    = TONE_PW,
    localparam int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1,
    localparam int unsigned MW   = $clog2(CH + 1)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [PW-1:0]  wr_period,
    input  logic [PW-1:0]  wr_high,
    input  logic [CH-1:0]  en,
    input  logic           sync,
    output logic [CH-1:0]  tone_out,
    output logic [CH-1:0]  wrap,
    output logic [CH-1:0]  pending,
    output logic [MW-1:0]  mix
);

    localparam int unsigned PSW = $clog2(CLK_F);

    logic [PSW-1:0] r_presc;
    logic [MW-1:0]  r_mix;
    logic           w_tick;
    logic [CH-1:0]  w_wr;
    logic [CH-1:0]  w_tone;
    logic [CH-1:0]  w_wrap;
    logic [CH-1:0]  w_pend;
    logic [MW-1:0]  w_pop;

    assign w_tick = (r_presc == PSW'(CLK_F - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
        end else if (sync || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PSW'(1);
        end
    end

    // Channel numbers at or above CH never match, so such writes are dropped.
    always_comb begin
        w_wr = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_wr[i] = wr_en && (32'(wr_ch) == i);
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        tone_channel #(
            .PW (PW)
        ) u_ch (
            .i_clk       (CLK),
            .i_rst_n     (RST_N),
            .i_tick      (w_tick),
            .i_sync      (sync),
            .i_wr        (w_wr[gi]),
            .i_wr_period (wr_period),
            .i_wr_high   (wr_high),
            .i_en        (en[gi]),
            .o_tone      (w_tone[gi]),
            .o_wrap      (w_wrap[gi]),
            .o_pending   (w_pend[gi])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_pop = w_pop + MW'(w_tone[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_pop;
        end
    end

    assign tone_out = w_tone;
    assign wrap     = w_wrap;
    assign pending  = w_pend;
    assign mix      = r_mix;

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank (CLK_F=4, CH=4, PW=8): expectations are queued
// per cycle when stimulus is driven and compared at the following negedges.
module tb_tone_bank;

    localparam int CLK_F = 4;
    localparam int CH    = 4;
    localparam int PW    = 8;
    localparam int KTONE = 0;
    localparam int KWRAP = 1;
    localparam int KPEND = 2;
    localparam int KMIX  = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [PW-1:0] wr_period;
    logic [PW-1:0] wr_high;
    logic [CH-1:0] en;
    logic          sync;
    logic [CH-1:0] tone_out;
    logic [CH-1:0] wrap;
    logic [CH-1:0] pending;
    logic [2:0]    mix;

    tone_bank #(
        .CLK_F (CLK_F),
        .CH    (CH),
        .PW    (PW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_period (wr_period),
        .wr_high   (wr_high),
        .en        (en),
        .sync      (sync),
        .tone_out  (tone_out),
        .wrap      (wrap),
        .pending   (pending),
        .mix       (mix)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         c;
        int         kind;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [7:0] observe(int k);
        case (k)
            KTONE:   return {4'b0, tone_out};
            KWRAP:   return {4'b0, wrap};
            KPEND:   return {4'b0, pending};
            default: return {5'b0, mix};
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            KTONE:   return "tone_out";
            KWRAP:   return "wrap";
            KPEND:   return "pending";
            default: return "mix";
        endcase
    endfunction

    // Expected tone bit n cycles after an aligning sync edge.
    function automatic logic tt(int n, int p, int h);
        return (p != 0) && ((((n - 1) / CLK_F) % p) < h);
    endfunction

    function automatic logic tw(int n, int p);
        return (p != 0) && (n > 0) && ((n % (CLK_F * p)) == 0);
    endfunction

    function automatic logic [2:0] pc(logic [3:0] t);
        return 3'($countones(t));
    endfunction

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            exp_t       e;
            logic [7:0] obs;
            e   = sb.pop_front();
            obs = observe(e.kind);
            n_cmp++;
            if (e.c != cyc) begin
                n_bad++;
                $error("FAIL late_%s cyc=%0d observed=missed expected_at=%0d", kname(e.kind), cyc,
                       e.c);
            end else begin
                assert (obs === e.v) else begin
                    n_bad++;
                    $error("FAIL %s cyc=%0d observed=%0h expected=%0h", kname(e.kind), cyc, obs,
                           e.v);
                end
            end
        end
    end

    task automatic push(int c, int k, logic [7:0] v);
        exp_t e;
        e.c    = c;
        e.kind = k;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic push_cycle(int c, logic [3:0] t, logic [3:0] w, logic [3:0] p,
                              logic [2:0] m, bit chk_mix);
        push(c, KTONE, {4'b0, t});
        push(c, KWRAP, {4'b0, w});
        push(c, KPEND, {4'b0, p});
        if (chk_mix) push(c, KMIX, {5'b0, m});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) step();
    endtask

    task automatic wr(int ch, int p, int h);
        wr_en     = 1'b1;
        wr_ch     = 2'(ch);
        wr_period = 8'(p);
        wr_high   = 8'(h);
    endtask

    task automatic wr_off();
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         s;
        int         r;
        int         guard;
        logic [3:0] t;
        logic [3:0] w;
        logic [3:0] p;
        logic [3:0] prev;

        RST_N = 1'b0;
        wr_en = 1'b0;
        wr_ch = '0;
        wr_period = '0;
        wr_high = '0;
        en = '0;
        sync = 1'b0;
        for (int c = 1; c <= 3; c++) push_cycle(c, 4'b0, 4'b0, 4'b0, 3'd0, 1'b1);
        wait_cyc(3);
        RST_N = 1'b1;

        // A: ch0 period 10 high 5 -> 20 high / 20 low, wrap every 40 cycles
        sync = 1'b1;
        wr(0, 10, 5);
        en = 4'b0001;
        s = cyc + 1;
        prev = '0;
        for (int n = 1; n <= 81; n++) begin
            t = {3'b0, tt(n, 10, 5)};
            w = {3'b0, tw(n, 10)};
            push_cycle(s + n, t, w, 4'b0, pc(prev), n >= 2);
            prev = t;
        end
        step();
        sync = 1'b0;
        wr_off();
        wait_cyc(s + 81);

        // B: ch1 8/2, rewritten mid-period to 4/4 -> loads at wrap, then constant high
        sync = 1'b1;
        wr(1, 8, 2);
        en = 4'b0010;
        s = cyc + 1;
        prev = '0;
        for (int n = 1; n <= 65; n++) begin
            t = {2'b0, (n <= 32) ? tt(n, 8, 2) : 1'b1, 1'b0};
            w = {2'b0, (n >= 32) && (((n - 32) % 16) == 0), 1'b0};
            p = {2'b0, (n >= 11) && (n <= 31), 1'b0};
            push_cycle(s + n, t, w, p, pc(prev), n >= 2);
            prev = t;
        end
        step();
        sync = 1'b0;
        wr_off();
        wait_cyc(s + 10);
        wr(1, 4, 4);
        step();
        wr_off();
        wait_cyc(s + 65);

        // C: silent ch3 gets 3/1 (loads at next tick), then a write coinciding with a load
        sync = 1'b1;
        en = 4'b1000;
        s = cyc + 1;
        prev = '0;
        for (int n = 1; n <= 60; n++) begin
            logic b;
            if (n <= 4) b = 1'b0;
            else if (n <= 40) b = (((n - 5) % 12) < 4);
            else if (n <= 52) b = (n <= 48);
            else b = 1'b1;
            t = {b, 3'b0};
            w = {(n >= 16) && (((n - 16) % 12) == 0), 3'b0};
            p = {((n >= 1) && (n <= 3)) || ((n >= 33) && (n <= 51)), 3'b0};
            push_cycle(s + n, t, w, p, pc(prev), n >= 2);
            prev = t;
        end
        step();
        sync = 1'b0;
        wr(3, 3, 1);
        step();
        wr_off();
        wait_cyc(s + 32);
        wr(3, 3, 2);
        step();
        wr_off();
        wait_cyc(s + 39);
        wr(3, 3, 3);
        step();
        wr_off();
        wait_cyc(s + 60);

        // D: ch0 5/2 and ch2 7/3 free-running, then sync with a direct write to ch3
        sync = 1'b1;
        wr(0, 5, 2);
        en = 4'b1101;
        step();
        sync = 1'b0;
        wr(2, 7, 3);
        step();
        wr_off();
        wait_cyc(cyc + 21);
        sync = 1'b1;
        wr(3, 6, 3);
        s = cyc + 1;
        push(s, KPEND, 8'h00);
        prev = '0;
        for (int n = 1; n <= 30; n++) begin
            t = {tt(n, 6, 3), tt(n, 7, 3), 1'b0, tt(n, 5, 2)};
            w = {tw(n, 6), tw(n, 7), 1'b0, tw(n, 5)};
            push_cycle(s + n, t, w, 4'b0, pc(prev), n >= 2);
            prev = t;
        end
        step();
        sync = 1'b0;
        wr_off();
        wait_cyc(s + 30);

        // E: all channels 2/1 with en=1011 -> mix toggles 0/3, channel 2 stays quiet
        wr(1, 2, 1);
        step();
        wr(2, 2, 1);
        step();
        wr(3, 2, 1);
        step();
        sync = 1'b1;
        wr(0, 2, 1);
        en = 4'b1011;
        s = cyc + 1;
        push(s, KPEND, 8'h00);
        prev = '0;
        for (int n = 1; n <= 25; n++) begin
            t = tt(n, 2, 1) ? 4'b1011 : 4'b0000;
            w = tw(n, 2) ? 4'b1011 : 4'b0000;
            p = (n >= 25) ? 4'b0100 : 4'b0000;
            push_cycle(s + n, t, w, p, pc(prev), n >= 2);
            prev = t;
        end
        step();
        sync = 1'b0;
        wr_off();
        wait_cyc(s + 24);
        wr(2, 5, 5);
        step();
        wr_off();
        step();

        // F: reset mid-period with ch2 pending -> everything clears at once
        RST_N = 1'b0;
        for (int c = 0; c <= 2; c++) push_cycle(s + 26 + c, 4'b0, 4'b0, 4'b0, 3'd0, 1'b1);
        step();
        step();
        RST_N = 1'b1;
        r = cyc;
        wr(0, 3, 3);
        prev = '0;
        for (int m = 1; m <= 14; m++) begin
            t = (m >= 5) ? 4'b0001 : 4'b0000;
            p = (m <= 3) ? 4'b0001 : 4'b0000;
            push_cycle(r + m, t, 4'b0, p, pc(prev), 1'b1);
            prev = t;
        end
        step();
        wr_off();
        wait_cyc(r + 14);

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL drain cyc=%0d observed=%0d_left expected=0_left", cyc, sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
